// File: rtl/ir_queue.sv
// ir_queue: show-ahead instruction buffer between IM and decode.
// Circular buffer with flush for branch/exception redirects; head is zero when empty.
module ir_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] im_din,
    input  logic              irwr,
    output logic              ir_rdy,
    output logic [DATA_W-1:0] im_dout,
    output logic              ir_vld,
    input  logic              ir_take,
    input  logic              flush,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push, pop;

    assign ir_rdy  = cnt_q != CNT_W'(DEPTH);
    assign ir_vld  = cnt_q != '0;
    assign count   = cnt_q;
    assign im_dout = ir_vld ? mem_q[rd_ptr_q] : '0;
    assign push    = irwr && ir_rdy;
    assign pop     = ir_take && ir_vld;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = flush ? '0 : (push ? wr_ptr_q + 1'b1 : wr_ptr_q);
        rd_ptr_d = flush ? '0 : (pop ? rd_ptr_q + 1'b1 : rd_ptr_q);
        cnt_d    = flush ? '0 : cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is never reset; stale words are hidden by the ir_vld gate on im_dout.
    always_ff @(posedge clk) begin
        if (rst && push && !flush)
            mem_q[wr_ptr_q] <= im_din;
    end
endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: scoreboard-driven checks of ir_queue ordering, full/empty, flush and reset.
module tb_ir_queue;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] im_din = '0;
    logic              irwr = 1'b0;
    logic              ir_rdy;
    logic [DATA_W-1:0] im_dout;
    logic              ir_vld;
    logic              ir_take = 1'b0;
    logic              flush = 1'b0;
    logic [CNT_W-1:0]  count;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] exp_head;
    int n_cmp = 0;
    int n_err = 0;

    ir_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .im_din(im_din), .irwr(irwr), .ir_rdy(ir_rdy),
        .im_dout(im_dout), .ir_vld(ir_vld), .ir_take(ir_take), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    // Drives one cycle and updates the scoreboard from the pre-edge model occupancy.
    task automatic tick(input logic w, input logic [DATA_W-1:0] d, input logic t, input logic f);
        logic acc_push, acc_pop;
        acc_push = w && (exp_q.size() != DEPTH);
        acc_pop  = t && (exp_q.size() != 0);
        irwr = w; im_din = d; ir_take = t; flush = f;
        @(posedge clk);
        #1;
        if (f) exp_q.delete();
        else begin
            if (acc_pop) void'(exp_q.pop_front());
            if (acc_push) exp_q.push_back(d);
        end
        irwr = 1'b0; im_din = '0; ir_take = 1'b0; flush = 1'b0;
    endtask

    task automatic pop_check(input string name);
        exp_head = exp_q[0];
        n_cmp++;
        if (!ir_vld || im_dout !== exp_head) begin
            n_err++;
            $display("FAIL %s: head vld=%b data=%h expected vld=1 data=%h", name, ir_vld, im_dout, exp_head);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic state_check(input string name);
        logic [DATA_W-1:0] e_dout;
        logic [CNT_W-1:0]  e_cnt;
        e_cnt  = CNT_W'(exp_q.size());
        e_dout = (exp_q.size() != 0) ? exp_q[0] : '0;
        n_cmp++;
        if (count !== e_cnt || ir_vld !== (e_cnt != 0) || ir_rdy !== (e_cnt != DEPTH) || im_dout !== e_dout) begin
            n_err++;
            $display("FAIL %s: count=%0d vld=%b rdy=%b dout=%h expected count=%0d vld=%b rdy=%b dout=%h",
                     name, count, ir_vld, ir_rdy, im_dout, e_cnt, e_cnt != 0, e_cnt != DEPTH, e_dout);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (ir_vld !== 1'b0 || ir_rdy !== 1'b1 || count !== '0 || im_dout !== '0) begin
            n_err++;
            $display("FAIL reset: vld=%b rdy=%b count=%0d dout=%h expected 0 1 0 0", ir_vld, ir_rdy, count, im_dout);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_single_write();
        tick(1'b1, 32'h2002000A, 1'b0, 1'b0);
        n_cmp++;
        if (im_dout !== 32'h2002000A || ir_vld !== 1'b1 || count !== CNT_W'(1) || ir_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL single_write: dout=%h vld=%b count=%0d rdy=%b expected 2002000a 1 1 1", im_dout, ir_vld, count, ir_rdy);
        end
        pop_check("single_pop");
        state_check("single_empty");
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 5; i++) tick(1'b1, DATA_W'(i * 'h11), 1'b0, 1'b0);
        n_cmp++;
        if (count !== CNT_W'(DEPTH) || ir_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full: count=%0d rdy=%b expected %0d 0", count, ir_rdy, DEPTH);
        end
        state_check("fill_state");
        for (int i = 0; i < DEPTH; i++) pop_check("fill_pop");
        n_cmp++;
        if (ir_vld !== 1'b0 || im_dout !== '0 || count !== '0) begin
            n_err++;
            $display("FAIL fill_drain: vld=%b dout=%h count=%0d expected 0 0 0", ir_vld, im_dout, count);
        end
    endtask

    task automatic test_stream_wrap();
        tick(1'b1, 32'h100, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            exp_head = exp_q[0];
            n_cmp++;
            if (im_dout !== exp_head) begin
                n_err++;
                $display("FAIL stream_order: dout=%h expected %h", im_dout, exp_head);
            end
            tick(1'b1, DATA_W'(32'h200 + i), 1'b1, 1'b0);
            n_cmp++;
            if (count !== CNT_W'(1)) begin
                n_err++;
                $display("FAIL stream_count: count=%0d expected 1", count);
            end
        end
        n_cmp++;
        if (im_dout !== 32'h209) begin
            n_err++;
            $display("FAIL stream_last: dout=%h expected 00000209", im_dout);
        end
        pop_check("stream_drain");
    endtask

    task automatic test_full_pop();
        for (int i = 1; i <= DEPTH; i++) tick(1'b1, DATA_W'(32'hA0 + i), 1'b0, 1'b0);
        tick(1'b1, 32'h99, 1'b1, 1'b0);
        n_cmp++;
        if (count !== CNT_W'(3) || im_dout !== 32'hA2) begin
            n_err++;
            $display("FAIL full_pop: count=%0d dout=%h expected 3 000000a2", count, im_dout);
        end
        tick(1'b1, 32'h99, 1'b0, 1'b0);
        state_check("full_refill");
        for (int i = 0; i < DEPTH - 1; i++) pop_check("full_drain");
        n_cmp++;
        if (im_dout !== 32'h99 || count !== CNT_W'(1)) begin
            n_err++;
            $display("FAIL full_tail: dout=%h count=%0d expected 00000099 1", im_dout, count);
        end
        pop_check("full_tail_pop");
    endtask

    task automatic test_flush();
        tick(1'b1, 32'h61, 1'b0, 1'b0);
        tick(1'b1, 32'h62, 1'b0, 1'b0);
        tick(1'b1, 32'h77, 1'b1, 1'b1);
        n_cmp++;
        if (count !== '0 || ir_vld !== 1'b0 || im_dout !== '0) begin
            n_err++;
            $display("FAIL flush: count=%0d vld=%b dout=%h expected 0 0 0", count, ir_vld, im_dout);
        end
        tick(1'b1, 32'h88, 1'b0, 1'b0);
        n_cmp++;
        if (count !== CNT_W'(1) || im_dout !== 32'h88) begin
            n_err++;
            $display("FAIL flush_next: count=%0d dout=%h expected 1 00000088", count, im_dout);
        end
        pop_check("flush_drain");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, DATA_W'(32'hC0 + i), 1'b0, 1'b0);
        state_check("arst_pre");
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        n_cmp++;
        if (ir_vld !== 1'b0 || count !== '0 || im_dout !== '0) begin
            n_err++;
            $display("FAIL arst_async: vld=%b count=%0d dout=%h expected 0 0 0", ir_vld, count, im_dout);
        end
        irwr = 1'b1; im_din = 32'hDEAD; ir_take = 1'b1;
        @(posedge clk); #1;
        irwr = 1'b0; ir_take = 1'b0; im_din = '0;
        state_check("arst_held");
        rst = 1'b1;
        tick(1'b1, 32'h5A, 1'b0, 1'b0);
        n_cmp++;
        if (count !== CNT_W'(1) || im_dout !== 32'h5A) begin
            n_err++;
            $display("FAIL arst_after: count=%0d dout=%h expected 1 0000005a", count, im_dout);
        end
        pop_check("arst_drain");
        state_check("arst_final");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_write();
        test_fill_overflow();
        test_stream_wrap();
        test_full_pop();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ir_queue.md
IR_QUEUE -- requirements
Module: ir_queue

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 32: instruction word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4: buffer entries; power of two, DEPTH >= 2.
REQ-003 The block SHALL have parameter CNT_W, default $clog2(DEPTH+1): occupancy counter width.

Interface
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 im_din  input  DATA_W  instruction word from IM.
REQ-007 irwr  input  1  write request; im_din is offered for capture.
REQ-008 ir_rdy  output  1  space available; a write is accepted when irwr=1 and ir_rdy=1.
REQ-009 im_dout  output  DATA_W  oldest buffered instruction (head).
REQ-010 ir_vld  output  1  im_dout holds a valid instruction.
REQ-011 ir_take  input  1  consumer accepts head; a pop occurs when ir_take=1 and ir_vld=1.
REQ-012 flush  input  1  synchronous discard of all entries (branch/exception redirect).
REQ-013 count  output  CNT_W  number of valid entries, 0..DEPTH.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH x DATA_W with write pointer, read pointer and occupancy count.
REQ-015 ir_rdy SHALL be (count != DEPTH), a function of registered state only; no combinational path from ir_take to ir_rdy.
REQ-016 ir_vld SHALL be (count != 0); im_dout SHALL equal the entry at the read pointer when ir_vld=1 and SHALL be all-zero when ir_vld=0.
REQ-017 Show-ahead semantics: a word accepted at edge N SHALL appear on im_dout with ir_vld=1 after edge N when the buffer was empty (1-cycle latency, no bypass in the same cycle).
REQ-018 Accepted push: im_din written at write pointer, write pointer +1 modulo DEPTH, count +1.
REQ-019 Accepted pop: read pointer +1 modulo DEPTH, count -1.
REQ-020 Simultaneous accepted push and pop: both pointers advance, count unchanged.
REQ-021 Full (count=DEPTH): irwr ignored, no entry overwritten, even when ir_take=1 in the same cycle.
REQ-022 Empty (count=0): ir_take ignored, pointers and count unchanged.
REQ-023 Pointer wrap: DEPTH-1 -> 0 with no bubble; order strictly FIFO across the wrap.
REQ-024 flush=1 at an edge SHALL set both pointers and count to 0 and override any push or pop in that cycle; the word on im_din in that cycle is dropped.
REQ-025 Words are never modified after capture; im_dout changes only on pop, flush, reset, or empty-to-non-empty transition.

Reset
REQ-026 rst=0 SHALL immediately, independent of clk, clear pointers and count to 0, giving ir_vld=0, ir_rdy=1, count=0, im_dout=0.
REQ-027 Storage array contents need not be cleared; they are unobservable because im_dout is gated by ir_vld.
REQ-028 Reset asserted mid-operation SHALL discard all entries; the first edge after rst returns high SHALL accept irwr normally.
REQ-029 irwr, ir_take and flush SHALL have no effect while rst=0.

Verification
REQ-030 Reset then single write: rst low then high, irwr=1 im_din=32'h2002000A one cycle -> after edge ir_vld=1, im_dout=32'h2002000A, count=1, ir_rdy=1.
REQ-031 Fill and overflow: DEPTH=4, write 0x11,0x22,0x33,0x44 then 0x55 with ir_take=0 -> count=4, ir_rdy=0, 0x55 dropped; four pops return 0x11,0x22,0x33,0x44, then ir_vld=0, im_dout=0.
REQ-032 Streaming across wrap: irwr=1 and ir_take=1 every cycle for 10 words after one preload -> count stays 1, output order matches input order across two pointer wraps.
REQ-033 Full with simultaneous pop: count=4, irwr=1 im_din=0x99, ir_take=1 -> head popped, 0x99 not written, count=3; next cycle 0x99 accepted, count=4.
REQ-034 Flush priority: count=2, flush=1 with irwr=1 and ir_take=1 -> after edge count=0, ir_vld=0, im_dout=0; next write appears as sole head.
REQ-035 Async reset mid-stream: count=3, drop rst between edges -> ir_vld=0, count=0, im_dout=0 before next edge; pops during reset return nothing.
